// File: rtl/note_sequencer.sv
// Note table walker: paces a song clock and issues one valid/ready spawn event per note.
// Optional NOTE_LEAD_EN: notes are due LEAD_TICKS early so they reach the hit line on time.
module note_sequencer #(
  parameter int NUM_NOTES  = 5,
  parameter int TIME_W     = 21,
  parameter int LANE_W     = 11,
  parameter int LEN_W      = 3,
  parameter int TICK_DIV   = 100000,
  parameter int LEAD_TICKS = 64,
  localparam int IW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_NOTES-1:0][TIME_W-1:0]    time_of_notes,
  input  logic [NUM_NOTES-1:0][LANE_W-1:0]    lane_of_notes,
  input  logic [NUM_NOTES-1:0][LEN_W-1:0]     length_of_notes,
  input  logic                                start,
  input  logic                                pause,
  output logic                                spawn_valid,
  input  logic                                spawn_ready,
  output logic [LANE_W-1:0]                   spawn_lane,
  output logic [LEN_W-1:0]                    spawn_length,
  output logic [IW-1:0]                       spawn_index,
  output logic [TIME_W-1:0]                   song_time,
  output logic                                busy,
  output logic                                done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // pointer must be able to sit one past the last entry
  localparam int XW = $clog2(NUM_NOTES + 1);
`ifdef NOTE_LEAD_EN
  localparam int LEAD = LEAD_TICKS;
`else
  localparam int LEAD = 0 * LEAD_TICKS;
`endif

  typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [XW-1:0] idx;
  logic [IW-1:0] cur;
  logic          at_end, due, tick, clk_en;

  assign at_end = (idx == XW'(NUM_NOTES));
  assign cur    = at_end ? '0 : IW'(idx);
  // widened by one bit so the lead offset can never wrap
  assign due    = ({1'b0, song_time} + (TIME_W+1)'(LEAD)) >= {1'b0, time_of_notes[cur]};
  assign tick   = (pre == PW'(TICK_DIV - 1));
  assign clk_en = ((state == RUN) || (state == EMIT)) && !pause;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pre          <= '0;
      idx          <= '0;
      song_time    <= '0;
      spawn_valid  <= 1'b0;
      spawn_lane   <= '0;
      spawn_length <= '0;
      spawn_index  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (start) begin
      // start from any state restarts; a pending event is dropped
      state       <= RUN;
      pre         <= '0;
      idx         <= '0;
      song_time   <= '0;
      spawn_valid <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
    end else begin
      if (clk_en) begin
        if (tick) begin
          pre <= '0;
          if (song_time != '1) song_time <= song_time + 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end
      case (state)
        RUN: begin
          if (at_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (length_of_notes[cur] == '0) begin
            idx <= idx + 1'b1;
          end else if (due) begin
            state        <= EMIT;
            spawn_valid  <= 1'b1;
            spawn_lane   <= lane_of_notes[cur];
            spawn_length <= length_of_notes[cur];
            spawn_index  <= cur;
          end
        end
        EMIT: begin
          if (spawn_ready) begin
            state       <= RUN;
            spawn_valid <= 1'b0;
            idx         <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Reader/consumer side of the note table: walks the note-time, note-lane and note-length arrays in index order against a running song clock.
- Issues one spawn event per note over a valid/ready handshake to the falling-note renderer.
- Sits between the note table and the lane/sprite logic.
- Owns the song-time counter, the note pointer and the start/pause/done control.

Parameters:
- NUM_NOTES, 5, number of table entries scanned (index 0..NUM_NOTES-1).
- TIME_W, 21, width of note time and song_time, in ticks.
- LANE_W, 11, width of lane field (pixel x-offset of lane).
- LEN_W, 3, width of note length field.
- TICK_DIV, 100000, clk cycles per song tick; must be >= 1.
- LEAD_TICKS, 64, spawn lead time in ticks; used only with the optional feature.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- time_of_notes, in, TIME_W x NUM_NOTES, note start times; ascending order expected.
- lane_of_notes, in, LANE_W x NUM_NOTES, note lanes.
- length_of_notes, in, LEN_W x NUM_NOTES, note lengths; 0 marks an empty slot.
- start, in, 1, single-cycle pulse; begins or restarts the song.
- pause, in, 1, level; freezes song time while high.
- spawn_valid, out, 1, spawn event present.
- spawn_ready, in, 1, consumer accepts event.
- spawn_lane, out, LANE_W, lane of presented note.
- spawn_length, out, LEN_W, length of presented note.
- spawn_index, out, clog2(NUM_NOTES), table index of presented note.
- song_time, out, TIME_W, current song tick.
- busy, out, 1, high in RUN or EMIT.
- done, out, 1, high in DONE.

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=IDLE; all outputs 0; prescaler=0; note pointer idx=0.
- States: IDLE, RUN, EMIT, DONE.
- IDLE: start -> RUN. song_time, prescaler and idx are cleared to 0 on entry to RUN.
- Song clock (RUN/EMIT, pause low):
  - Prescaler counts 0..TICK_DIV-1.
  - On wrap, song_time increments, saturating at all-ones.
  - pause high holds the prescaler and song_time. A pending handshake still completes.
- RUN, evaluated every cycle:
  - idx==NUM_NOTES -> DONE.
  - Else if length_of_notes[idx]==0 -> idx+1, stay in RUN (skip costs one cycle, no emission).
  - Else if song_time >= time_of_notes[idx] -> EMIT.
  - EMIT entry latches spawn_lane/length/index from entry idx and raises spawn_valid on the next edge. Latency is 1 cycle from the compare becoming true.
- EMIT:
  - spawn_valid and payload stay stable until spawn_ready is sampled high.
  - On handshake: spawn_valid drops on the same edge, idx+1, return to RUN. At most one emission per 2 cycles.
  - Song time keeps advancing in EMIT.
- Unsorted table: an entry whose time has already passed is emitted immediately when reached. No reordering.
- Multiple notes due at the same time are emitted back-to-back in index order.
- DONE: done=1, busy=0, song_time frozen. start -> RUN (restart).
- start while in RUN/EMIT: restart. spawn_valid drops, idx=0, song_time=0, state RUN. The pending event is discarded.
- Reset mid-handshake: spawn_valid drops asynchronously.
- Table inputs are sampled only at compare/latch time and may change between notes.

Optional Feature:
- Macro NOTE_LEAD_EN.
- Defined: the due compare is song_time + LEAD_TICKS >= time_of_notes[idx]. The sum is computed TIME_W+1 bits wide, so there is no wrap. Notes spawn LEAD_TICKS early so they reach the hit line on time.
- Undefined: compare is song_time >= time_of_notes[idx]. LEAD_TICKS is unused.

Test Plan:
- Setup for all tests: TICK_DIV=4. Table: t={8,128,400,800,900}, lane={128,256,1,5,2}, len={1,4,1,2,1}. spawn_ready tied 1.
  - Pulse start -> spawn_valid one cycle after song_time=8 with lane=128, len=1, idx=0. Then one after song_time=128 with lane=256, len=4. Five events total, then done=1 after the idx 4 handshake.
- spawn_ready held 0 for 20 cycles at note 0 -> payload stable (lane=128), spawn_valid high throughout, song_time still advances. Release -> one handshake only.
- Entries 1 and 2 set to len=0 -> only indices 0, 3, 4 emitted. No spawn_valid pulses for the skipped slots.
- pause high for 40 cycles at song_time=50 -> song_time stays 50. Note 1 is emitted 40 cycles later than the no-pause run.
- start pulse at song_time=200, then reset asserted asynchronously during EMIT:
  - start -> idx=0, song_time=0, note 0 re-emitted.
  - reset -> all outputs 0 with no clock edge.
- NOTE_LEAD_EN defined, LEAD_TICKS=64 -> note 1 (t=128) spawns at song_time=64. Note 0 (t=8) spawns at song_time=0 immediately after start.
